mc_bus_bridge: RTL and testbench

Bridge between the MCU asynchronous parallel bus (mc_ce/mc_we/mc_oe, 6-bit address, 16-bit data) and the FPGA clock domain. Synchronises bus strobes, turns completed MCU writes into single-cycle register-write strobes, and manages the address-0x00 data window as a TX FIFO (MCU→protocol engine) and an RX FIFO (engine→MCU). It sits directly upstream of the protocol engine and register file inside top. It also generates irq0/irq1 and the mc_data tristate enable.

---
 rtl/mc_bus_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_mc_bus_bridge.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_bus_bridge.sv
// MCU async parallel bus to clock-domain bridge.
// Register strobes, TX/RX data-window FIFOs, IRQs, pad drive enable.
module mc_bus_bridge_fifo #(
   parameter int W  = 16,
   parameter int AW = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] mem [2**AW];
   logic [AW:0]  wp;
   logic [AW:0]  rp;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wp == rp);
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot, so a push at full still lands
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rp[AW-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + (AW+1)'(1);
         if (do_pop)  rp <= rp + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wp[AW-1:0]] <= din;
   end
endmodule

module mc_bus_bridge #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int FIFO_AW    = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  mc_ce,
   input  logic                  mc_we,
   input  logic                  mc_oe,
   input  logic [ADDR_WIDTH-1:0] mc_add,
   input  logic [DATA_WIDTH-1:0] mc_data_in,
   output logic [DATA_WIDTH-1:0] mc_data_out,
   output logic                  mc_data_oe,
   output logic                  reg_wr,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  irq0,
   output logic                  irq1
);
   localparam logic [ADDR_WIDTH-1:0] A_FIFO = '0;
   localparam logic [ADDR_WIDTH-1:0] A_CTRL = '1;

   // bit 0 = s1, bit 1 = s2, bit 2 = s3
   logic [2:0]            ce_s;
   logic [2:0]            we_s;
   logic [2:0]            oe_s;
   logic [ADDR_WIDTH-1:0] add_s1, add_s2, add_s3;
   logic [DATA_WIDTH-1:0] dat_s1, dat_s2, dat_s3;
   logic [2:0]            warm;

   logic wr_pend, rd_act, rd_pop;
   logic tx_ovf, rx_unf;
   logic [ADDR_WIDTH-1:0] reg_addr_q;

   logic we_fall, we_rise, commit;
   logic rd_start, rd_end, rd_fifo, rd_ctrl, rd_reg;
   logic wr_fifo, wr_ctrl, wr_reg;
   logic tx_push, tx_pop, tx_full, tx_empty, tx_drop;
   logic rx_pop, rx_full, rx_empty;
   logic [DATA_WIDTH-1:0] rx_head;
   logic [DATA_WIDTH-1:0] status;
   logic [DATA_WIDTH-1:0] rd_word;

   always_ff @(posedge clock) begin
      if (reset) begin
         ce_s   <= '1;
         we_s   <= '1;
         oe_s   <= '1;
         add_s1 <= '0;
         add_s2 <= '0;
         add_s3 <= '0;
         dat_s1 <= '0;
         dat_s2 <= '0;
         dat_s3 <= '0;
         warm   <= '0;
      end else begin
         ce_s   <= {ce_s[1:0], mc_ce};
         we_s   <= {we_s[1:0], mc_we};
         oe_s   <= {oe_s[1:0], mc_oe};
         add_s1 <= mc_add;
         add_s2 <= add_s1;
         add_s3 <= add_s2;
         dat_s1 <= mc_data_in;
         dat_s2 <= dat_s1;
         dat_s3 <= dat_s2;
         warm   <= {warm[1:0], 1'b1};
      end
   end

   // edges only count once s2/s3 hold real samples taken after reset
   assign we_fall  = warm[2] && !we_s[1] && we_s[2];
   assign we_rise  = we_s[1] && !we_s[2];
   assign commit   = wr_pend && we_rise && !ce_s[2];
   assign rd_start = warm[2] && !oe_s[1] && oe_s[2] && !ce_s[1] && we_s[1];
   assign rd_end   = rd_act && oe_s[1] && !oe_s[2];

   assign wr_fifo = (add_s3 == A_FIFO);
   assign wr_ctrl = (add_s3 == A_CTRL);
   assign wr_reg  = commit && !wr_fifo && !wr_ctrl;
   assign rd_fifo = (add_s2 == A_FIFO);
   assign rd_ctrl = (add_s2 == A_CTRL);
   assign rd_reg  = rd_start && !rd_fifo && !rd_ctrl;

   assign tx_push = commit && wr_fifo;
   assign tx_pop  = tx_valid && tx_ready;
   assign tx_drop = tx_push && tx_full && !tx_pop;
   assign rx_pop  = rd_end && rd_pop;

   assign status = {{(DATA_WIDTH-6){1'b0}}, rx_unf, tx_ovf,
                    rx_full, rx_empty, tx_full, tx_empty};

   always_comb begin
      rd_word = reg_rdata;
      unique case (1'b1)
         rd_fifo: rd_word = rx_empty ? '0 : rx_head;
         rd_ctrl: rd_word = status;
         default: rd_word = reg_rdata;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_pend     <= 1'b0;
         rd_act      <= 1'b0;
         rd_pop      <= 1'b0;
         tx_ovf      <= 1'b0;
         rx_unf      <= 1'b0;
         reg_wr      <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata   <= '0;
         mc_data_out <= '0;
         mc_data_oe  <= 1'b0;
      end else begin
         if (we_fall)      wr_pend <= 1'b1;
         else if (we_rise) wr_pend <= 1'b0;
         if (rd_start) begin
            rd_act      <= 1'b1;
            rd_pop      <= rd_fifo && !rx_empty;
            mc_data_out <= rd_word;
            reg_addr_q  <= add_s2;
         end else if (rd_end) begin
            rd_act <= 1'b0;
            rd_pop <= 1'b0;
         end
         tx_ovf <= (tx_ovf && !(commit && wr_ctrl && dat_s3[0])) || tx_drop;
         rx_unf <= (rx_unf && !(commit && wr_ctrl && dat_s3[1]))
                   || (rd_start && rd_fifo && rx_empty);
         reg_wr <= wr_reg;
         if (wr_reg) begin
            reg_addr_q <= add_s3;
            reg_wdata  <= dat_s3;
         end
         mc_data_oe <= !oe_s[1] && !ce_s[1];
      end
   end

   assign reg_addr = rd_reg ? add_s2 : reg_addr_q;

   mc_bus_bridge_fifo #(.W(DATA_WIDTH), .AW(FIFO_AW)) u_tx (
      .clock (clock),
      .reset (reset),
      .push  (tx_push),
      .din   (dat_s3),
      .pop   (tx_ready),
      .head  (tx_data),
      .full  (tx_full),
      .empty (tx_empty)
   );

   mc_bus_bridge_fifo #(.W(DATA_WIDTH), .AW(FIFO_AW)) u_rx (
      .clock (clock),
      .reset (reset),
      .push  (rx_valid),
      .din   (rx_data),
      .pop   (rx_pop),
      .head  (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

   assign tx_valid = !tx_empty;
   assign rx_ready = !rx_full;
   assign irq0     = !rx_empty;
   assign irq1     = tx_ovf || rx_unf;
endmodule

// File: tb/tb_mc_bus_bridge.sv
// Bench for mc_bus_bridge: vector table, scoreboards for reg writes,
// TX and RX data, plus hand sequences for FIFO limits and reset.
module tb_mc_bus_bridge;
   logic        clock = 1'b0;
   logic        reset;
   logic        mc_ce, mc_we, mc_oe;
   logic [5:0]  mc_add;
   logic [15:0] mc_data_in;
   logic [15:0] mc_data_out;
   logic        mc_data_oe;
   logic        reg_wr;
   logic [5:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic [15:0] reg_rdata;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        irq0, irq1;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_pulses = 0;
   int tx_pops = 0;
   bit watch = 0;
   bit rdy_seen = 0;

   logic [21:0] exp_wr[$];
   logic [15:0] exp_tx[$];
   logic [15:0] exp_rx[$];

   typedef struct {
      bit          is_wr;
      logic [5:0]  addr;
      logic [15:0] val;
   } vec_t;

   vec_t vecs[8];

   mc_bus_bridge dut (
      .clock       (clock),
      .reset       (reset),
      .mc_ce       (mc_ce),
      .mc_we       (mc_we),
      .mc_oe       (mc_oe),
      .mc_add      (mc_add),
      .mc_data_in  (mc_data_in),
      .mc_data_out (mc_data_out),
      .mc_data_oe  (mc_data_oe),
      .reg_wr      (reg_wr),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_rdata   (reg_rdata),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .irq0        (irq0),
      .irq1        (irq1)
   );

   always #5 clock = ~clock;

   // register file stand-in: combinational on reg_addr
   assign reg_rdata = 16'hC000 | {10'b0, reg_addr};

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic [21:0] mon_wr;
   logic [15:0] mon_tx;
   always @(negedge clock) begin
      if (!reset && reg_wr) begin
         wr_pulses++;
         if (exp_wr.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL reg_wr_unexpected: got addr %h data %h expected none",
                     reg_addr, reg_wdata);
         end else begin
            mon_wr = exp_wr.pop_front();
            chk("reg_wr_data", {10'b0, reg_addr, reg_wdata}, {10'b0, mon_wr});
         end
      end
      if (!reset && tx_valid && tx_ready) begin
         tx_pops++;
         if (exp_tx.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_unexpected: got %h expected none", tx_data);
         end else begin
            mon_tx = exp_tx.pop_front();
            chk("tx_data", {16'b0, tx_data}, {16'b0, mon_tx});
         end
      end
      if (watch && rx_ready) rdy_seen = 1'b1;
   end

   task automatic mcu_write(input logic [5:0] a, input logic [15:0] d);
      bit is_reg;
      is_reg = (a != 6'h00) && (a != 6'h3F);
      @(negedge clock);
      mc_add = a;
      mc_data_in = d;
      mc_ce = 1'b0;
      mc_we = 1'b0;
      repeat (4) @(negedge clock);
      mc_we = 1'b1;
      if (is_reg) exp_wr.push_back({a, d});
      if (a == 6'h00 && exp_tx.size() < 16) exp_tx.push_back(d);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         if (k < 3) chk("wr_early", reg_wr, 0);
         else       chk("wr_at_3", reg_wr, is_reg);
      end
      @(negedge clock);
      chk("wr_one_cycle", reg_wr, 0);
      @(negedge clock);
      mc_ce = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic mcu_read(input logic [5:0] a, output logic [15:0] d);
      @(negedge clock);
      mc_add = a;
      mc_ce = 1'b0;
      mc_oe = 1'b0;
      repeat (2) @(negedge clock);
      chk("oe_early", mc_data_oe, 0);
      @(negedge clock);
      chk("oe_at_3", mc_data_oe, 1);
      repeat (3) @(negedge clock);
      d = mc_data_out;
      mc_oe = 1'b1;
      mc_ce = 1'b1;
      repeat (4) @(negedge clock);
      chk("oe_off", mc_data_oe, 0);
   endtask

   task automatic eng_push(input logic [15:0] d);
      @(negedge clock);
      rx_data = d;
      rx_valid = 1'b1;
      if (rx_ready) exp_rx.push_back(d);
      @(negedge clock);
      rx_valid = 1'b0;
   endtask

   task automatic drain_tx();
      @(negedge clock);
      tx_ready = 1'b1;
      for (int i = 0; i < 40 && tx_valid; i++) @(negedge clock);
      chk("tx_drained", tx_valid, 0);
      chk("tx_sb_empty", exp_tx.size(), 0);
      tx_ready = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      int p0;
      int w0;

      vecs[0] = '{1'b1, 6'h19, 16'h0003};
      vecs[1] = '{1'b1, 6'h1A, 16'h0003};
      vecs[2] = '{1'b0, 6'h19, 16'hC019};
      vecs[3] = '{1'b0, 6'h3E, 16'hC03E};
      vecs[4] = '{1'b1, 6'h01, 16'hABCD};
      vecs[5] = '{1'b1, 6'h3E, 16'h8001};
      vecs[6] = '{1'b0, 6'h3F, 16'h0005};
      vecs[7] = '{1'b0, 6'h01, 16'hC001};

      reset = 1'b1;
      mc_ce = 1'b1;
      mc_we = 1'b1;
      mc_oe = 1'b1;
      mc_add = '0;
      mc_data_in = '0;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data = '0;
      repeat (3) @(negedge clock);
      chk("rst_data_out", mc_data_out, 0);
      chk("rst_data_oe", mc_data_oe, 0);
      chk("rst_reg_wr", reg_wr, 0);
      chk("rst_reg_addr", reg_addr, 0);
      chk("rst_reg_wdata", reg_wdata, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_rx_ready", rx_ready, 1);
      chk("rst_irq0", irq0, 0);
      chk("rst_irq1", irq1, 0);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].is_wr) begin
            mcu_write(vecs[i].addr, vecs[i].val);
         end else begin
            mcu_read(vecs[i].addr, d);
            chk($sformatf("vec%0d_read", i), d, vecs[i].val);
         end
      end
      chk("tbl_tx_idle", tx_valid, 0);
      chk("tbl_wr_sb", exp_wr.size(), 0);

      // TX ordering with engine stalled, then released
      mcu_write(6'h00, 16'h0055);
      mcu_write(6'h00, 16'h0001);
      mcu_write(6'h00, 16'h0002);
      mcu_write(6'h00, 16'h0003);
      chk("tx_valid_held", tx_valid, 1);
      chk("tx_head", tx_data, 16'h0055);
      p0 = tx_pops;
      drain_tx();
      chk("tx_pop_count", tx_pops - p0, 4);

      // TX overflow on the 17th word
      for (int i = 0; i < 17; i++) mcu_write(6'h00, 16'h0200 + 16'(i));
      mcu_read(6'h3F, d);
      chk("ovf_status", d, 16'h0016);
      chk("ovf_irq1", irq1, 1);
      mcu_write(6'h3F, 16'h0001);
      chk("ovf_clear", irq1, 0);
      p0 = tx_pops;
      drain_tx();
      chk("ovf_pops", tx_pops - p0, 16);

      // RX reads and underflow
      eng_push(16'hA5A5);
      eng_push(16'h1234);
      chk("rx_irq0", irq0, 1);
      mcu_read(6'h00, d);
      chk("rx_rd1", d, exp_rx.pop_front());
      chk("rx_irq0_mid", irq0, 1);
      mcu_read(6'h00, d);
      chk("rx_rd2", d, exp_rx.pop_front());
      chk("rx_irq0_done", irq0, 0);
      mcu_read(6'h00, d);
      chk("rx_unf_data", d, 16'h0000);
      chk("rx_unf_irq1", irq1, 1);
      mcu_read(6'h3F, d);
      chk("rx_unf_status", d, 16'h0025);
      eng_push(16'h7777);
      mcu_read(6'h00, d);
      chk("rx_after_unf", d, exp_rx.pop_front());
      mcu_write(6'h3F, 16'h0002);
      chk("unf_clear", irq1, 0);

      // RX full: engine push lands in the same cycle as the MCU pop
      for (int i = 0; i < 16; i++) eng_push(16'h0100 + 16'(i));
      chk("rx_full_rdy", rx_ready, 0);
      chk("rx_full_sb", exp_rx.size(), 16);
      @(negedge clock);
      rx_data = 16'hBEEF;
      rx_valid = 1'b1;
      rdy_seen = 1'b0;
      watch = 1'b1;
      mcu_read(6'h00, d);
      chk("full_head", d, exp_rx.pop_front());
      exp_rx.push_back(16'hBEEF);
      rx_valid = 1'b0;
      watch = 1'b0;
      chk("full_rdy_held", rdy_seen, 0);
      chk("full_still", rx_ready, 0);
      for (int i = 0; i < 16; i++) begin
         mcu_read(6'h00, d);
         chk($sformatf("full_order%0d", i), d, exp_rx.pop_front());
      end
      chk("full_drained", irq0, 0);

      // reset while mc_we is low: the later rising edge must be ignored
      for (int j = 0; j < 2; j++) begin
         w0 = wr_pulses;
         @(negedge clock);
         mc_add = (j == 0) ? 6'h05 : 6'h00;
         mc_data_in = 16'h1111;
         mc_ce = 1'b0;
         mc_we = 1'b0;
         repeat (2) @(negedge clock);
         reset = 1'b1;
         @(negedge clock);
         reset = 1'b0;
         repeat (3) @(negedge clock);
         mc_we = 1'b1;
         repeat (6) @(negedge clock);
         mc_ce = 1'b1;
         @(negedge clock);
         chk($sformatf("rst_mid_wr%0d", j), wr_pulses - w0, 0);
         chk($sformatf("rst_mid_tx%0d", j), tx_valid, 0);
      end
      mcu_write(6'h07, 16'h4242);
      chk("post_rst_wr", exp_wr.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
